fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, data word width in bits.
REQ-002 Parameter BURST_LEN, default 8, maximum words per grant; legal range 1..256.
REQ-003 Parameter CNT_W, default 8, burst counter width; SHALL satisfy 2^CNT_W >= BURST_LEN.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req  input  4  per-requester request; bit i held high while requester i has a word on din.
REQ-007 din  input  4*FIFO_WIDTH  packed requester data; requester i at din[i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-008 full  input  1  FIFO full flag.
REQ-009 gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-010 ack  output  4  per-requester word-accepted strobe.
REQ-011 fifo_wen  output  1  FIFO write enable.
REQ-012 fifo_din  output  FIFO_WIDTH  FIFO write data.

Function
REQ-013 FSM SHALL have exactly two states, IDLE and BURST, plus a 2-bit round-robin pointer rr_ptr and a CNT_W-bit counter beat_cnt.
REQ-014 IDLE, req != 0: select first requester with req set, scanning rr_ptr, rr_ptr+1, ... mod 4; next edge: gnt <= one-hot of winner, beat_cnt <= 0, state <= BURST.
REQ-015 IDLE, req == 0: remain IDLE, gnt stays 0.
REQ-016 Transfer condition (combinational): state == BURST and req[g] == 1 and full == 0, g = granted index.
REQ-017 fifo_wen SHALL equal the transfer condition; fifo_din SHALL equal din slice g when state == BURST, else 0.
REQ-018 ack[i] SHALL equal gnt[i] AND fifo_wen; at most one ack bit high per cycle.
REQ-019 Each transfer: beat_cnt increments by 1; full == 1 stalls (no write, no ack, beat_cnt holds, grant held).
REQ-020 Burst ends at next edge when a transfer occurs with beat_cnt == BURST_LEN-1, or when req[g] == 0 in BURST.
REQ-021 Burst end: gnt <= 0, state <= IDLE, rr_ptr <= g+1 mod 4; one idle arbitration cycle always separates grants.
REQ-022 Non-granted requesters' req changes SHALL not affect the current burst.
REQ-023 Requester i drops req[i] mid-burst: no transfer that cycle; burst ends per REQ-020.
REQ-024 full asserted indefinitely in BURST: grant held, no timeout.
REQ-025 Latency: req rising in IDLE to first possible fifo_wen = 1 clock cycle.

Reset
REQ-026 rst_n low SHALL immediately force state = IDLE, gnt = 0, rr_ptr = 0, beat_cnt = 0; hence fifo_wen = 0, ack = 0, fifo_din = 0.
REQ-027 Reset asserted mid-burst SHALL abort the burst; no write occurs while rst_n is low.
REQ-028 After rst_n rises, requester 0 has highest priority for the first arbitration.

Verification
REQ-029 Reset: rst_n low between edges with gnt = 0010 -> gnt = 0000 and fifo_wen = 0 before the next edge; after release, req = 1111 -> gnt = 0001.
REQ-030 Round-robin: req = 1111 held, full = 0, BURST_LEN = 8 -> grants 0001, 0010, 0100, 1000, 0001 in order; each 8 writes; 1 idle cycle between grants.
REQ-031 Backpressure: req = 0001, full high for cycles 3-5 of burst -> fifo_wen/ack low those cycles, exactly 8 writes total, beat_cnt unchanged during stall.
REQ-032 Early release: req[2] high for 3 words then low -> 3 writes of din slice 2, gnt 0100 -> 0000, next winner scan starts at requester 3.
REQ-033 Data routing: din slices 0xA000/0xB001/0xC002/0xD003, req = 1010 -> fifo_din = 0xB001 during grant 1, 0xD003 during grant 3; ack bit matches gnt bit.
REQ-034 Single-beat: BURST_LEN = 1, req = 0011 -> alternating 1-word grants, gnt 0001, 0000, 0010, 0000, 0001, ...

Source files
------------

// File: rtl/fifo_wr_arb.sv
// Four-requester round-robin arbiter feeding a single FIFO write port.
// A grant lasts up to BURST_LEN words; one idle arbitration cycle separates grants.
module fifo_wr_arb #(
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 8,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              req,
  input  logic [4*FIFO_WIDTH-1:0] din,
  input  logic                    full,
  output logic [3:0]              gnt,
  output logic [3:0]              ack,
  output logic                    fifo_wen,
  output logic [FIFO_WIDTH-1:0]   fifo_din,
  output logic                    dbg_state,
  output logic [CNT_W-1:0]        dbg_beat_cnt
);

  // Handshake: a word moves from requester g to the FIFO in any cycle where
  // gnt[g] & req[g] & !full; that cycle fifo_wen and ack[g] are high together.

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  state_t           state, state_n;
  logic [3:0]       gnt_n;
  logic [1:0]       rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
  logic [1:0]       g;
  logic             xfer;
  logic [1:0]       scan_idx;
  logic [1:0]       win;
  logic             win_vld;

  always_comb begin
    case (gnt)
      4'b0010: g = 2'd1;
      4'b0100: g = 2'd2;
      4'b1000: g = 2'd3;
      default: g = 2'd0;
    endcase
  end

  assign xfer     = (state == BURST) && req[g] && !full;
  assign fifo_wen = xfer;
  assign ack      = gnt & {4{xfer}};
  assign fifo_din = (state == BURST) ? din[g*FIFO_WIDTH +: FIFO_WIDTH] : '0;

  // Scan from the far end back to rr_ptr so the last hit is the highest priority.
  always_comb begin
    win      = 2'd0;
    win_vld  = 1'b0;
    scan_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = rr_ptr + 2'(k);
      if (req[scan_idx]) begin
        win     = scan_idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    case (state)
      IDLE: begin
        if (win_vld) begin
          gnt_n      = 4'b0001 << win;
          beat_cnt_n = '0;
          state_n    = BURST;
        end
      end
      BURST: begin
        if (!req[g]) begin
          gnt_n    = 4'b0000;
          rr_ptr_n = g + 2'd1;
          state_n  = IDLE;
        end else if (!full) begin
          beat_cnt_n = beat_cnt + CNT_W'(1);
          if (beat_cnt == LAST_BEAT) begin
            gnt_n    = 4'b0000;
            rr_ptr_n = g + 2'd1;
            state_n  = IDLE;
          end
        end
      end
      default: begin
        gnt_n   = 4'b0000;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      rr_ptr   <= 2'd0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  assign dbg_state    = state;
  assign dbg_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: two instances (BURST_LEN 8 and 1) share stimulus and are
// compared each cycle against a per-instance reference model of the grant rules.
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [63:0] din = '0;
  logic        full = 1'b0;

  logic [3:0]  gnt_o[2];
  logic [3:0]  ack_o[2];
  logic        wen_o[2];
  logic [15:0] fdin_o[2];
  logic        st_o[2];
  logic [7:0]  beat8;
  logic [0:0]  beat1;
  logic [7:0]  beat_o[2];

  assign beat_o[0] = beat8;
  assign beat_o[1] = {7'b0, beat1};

  always #5 clk = ~clk;

  fifo_wr_arb #(.FIFO_WIDTH(16), .BURST_LEN(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .full(full),
    .gnt(gnt_o[0]), .ack(ack_o[0]), .fifo_wen(wen_o[0]), .fifo_din(fdin_o[0]),
    .dbg_state(st_o[0]), .dbg_beat_cnt(beat8)
  );

  fifo_wr_arb #(.FIFO_WIDTH(16), .BURST_LEN(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .full(full),
    .gnt(gnt_o[1]), .ack(ack_o[1]), .fifo_wen(wen_o[1]), .fifo_din(fdin_o[1]),
    .dbg_state(st_o[1]), .dbg_beat_cnt(beat1)
  );

  // Reference model: who owns the port (-1 = nobody), words moved so far,
  // and where the next arbitration scan starts.
  int owner[2] = '{-1, -1};
  int words[2] = '{0, 0};
  int start[2] = '{0, 0};
  int blen[2]  = '{8, 1};
  int cmask[2] = '{255, 1};

  int n_cmp = 0;
  int n_mis = 0;

  logic [3:0] gq[$];
  int         wq[$];
  logic [3:0] prev_g = 4'b0000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      owner[m] = -1;
      words[m] = 0;
      start[m] = 0;
    end
  endtask

  task automatic check_all();
    logic [3:0]  eg, ea;
    logic        ew;
    logic [15:0] ed;
    for (int m = 0; m < 2; m++) begin
      if (owner[m] < 0) begin
        eg = 4'b0000; ea = 4'b0000; ew = 1'b0; ed = 16'h0000;
      end else begin
        eg = 4'b0001 << owner[m];
        ew = req[owner[m]] && !full;
        ed = din[owner[m]*16 +: 16];
        ea = ew ? eg : 4'b0000;
        chk($sformatf("beat_cnt[dut%0d]", m), 64'(beat_o[m]), 64'(words[m] & cmask[m]));
      end
      chk($sformatf("gnt[dut%0d]", m), 64'(gnt_o[m]), 64'(eg));
      chk($sformatf("ack[dut%0d]", m), 64'(ack_o[m]), 64'(ea));
      chk($sformatf("fifo_wen[dut%0d]", m), 64'(wen_o[m]), 64'(ew));
      chk($sformatf("fifo_din[dut%0d]", m), 64'(fdin_o[m]), 64'(ed));
      chk($sformatf("state[dut%0d]", m), 64'(st_o[m]), 64'(owner[m] >= 0));
    end
  endtask

  task automatic model_edge();
    int idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (owner[m] < 0) begin
        for (int k = 3; k >= 0; k--) begin
          idx = (start[m] + k) % 4;
          if (req[idx]) owner[m] = idx;
        end
        words[m] = 0;
      end else if (!req[owner[m]]) begin
        start[m] = (owner[m] + 1) % 4;
        owner[m] = -1;
      end else if (!full) begin
        words[m]++;
        if (words[m] == blen[m]) begin
          start[m] = (owner[m] + 1) % 4;
          owner[m] = -1;
        end
      end
    end
  endtask

  task automatic track();
    int last;
    if (gnt_o[0] != 4'b0000 && prev_g == 4'b0000) begin
      gq.push_back(gnt_o[0]);
      wq.push_back(0);
    end
    if (wen_o[0] && wq.size() > 0) begin
      last = wq.size() - 1;
      wq[last] = wq[last] + 1;
    end
    prev_g = gnt_o[0];
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    track();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_log();
    gq.delete();
    wq.delete();
    prev_g = 4'b0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    full  = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    clear_log();
  endtask

  logic [3:0] rr_exp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] sb_exp[6] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000};

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values while rst_n is held low from time zero.
    tick();
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a grant, then priority restarts at 0.
    req = 4'b0010;
    tick();
    chk("pre_rst_gnt", 64'(gnt_o[0]), 64'(4'b0010));
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 64'(gnt_o[0]), 64'(4'b0000));
    chk("async_rst_wen", 64'(wen_o[0]), 64'(1'b0));
    model_reset();
    req = 4'b1111;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", 64'(gnt_o[0]), 64'(4'b0001));

    // Round-robin rotation with all requesters active.
    do_reset();
    req = 4'b1111;
    for (int t = 0; t < 46; t++) tick();
    chk("rr_ngrants", 64'(gq.size() >= 5), 64'(1));
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_seq%0d", i), 64'((i < gq.size()) ? gq[i] : 4'hf), 64'(rr_exp[i]));
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_words%0d", i), 64'((i < wq.size()) ? wq[i] : -1), 64'(8));

    // Backpressure in burst cycles 3-5.
    do_reset();
    req = 4'b0001;
    din = 64'h0000_0000_0000_1234;
    for (int t = 1; t <= 13; t++) begin
      full = (t >= 4 && t <= 6);
      tick();
    end
    req = 4'b0000;
    tick();
    chk("bp_words", 64'((wq.size() > 0) ? wq[0] : -1), 64'(8));

    // Early release by requester 2 after three words.
    do_reset();
    din = 64'h3333_2222_1111_0000;
    req = 4'b0100;
    for (int t = 0; t < 4; t++) tick();
    req = 4'b0000;
    tick();
    req = 4'b1111;
    tick();
    tick();
    chk("early_words", 64'((wq.size() > 0) ? wq[0] : -1), 64'(3));
    chk("early_next_gnt", 64'(gnt_o[0]), 64'(4'b1000));

    // Data routing for requesters 1 and 3.
    do_reset();
    din = 64'hD003_C002_B001_A000;
    req = 4'b1010;
    tick();
    tick();
    chk("route_gnt1", 64'(gnt_o[0]), 64'(4'b0010));
    chk("route_din1", 64'(fdin_o[0]), 64'(16'hB001));
    chk("route_ack1", 64'(ack_o[0]), 64'(4'b0010));
    for (int t = 0; t < 9; t++) tick();
    chk("route_gnt3", 64'(gnt_o[0]), 64'(4'b1000));
    chk("route_din3", 64'(fdin_o[0]), 64'(16'hD003));
    for (int t = 0; t < 8; t++) tick();

    // Randomised traffic with occasional asynchronous resets.
    do_reset();
    for (int t = 0; t < 500; t++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      full = ($urandom_range(0, 3) == 0);
      din  = {$urandom(), $urandom()};
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rand_async_gnt", 64'(gnt_o[0] | gnt_o[1]), 64'(4'b0000));
        model_reset();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    // Single-beat bursts alternate between requesters 0 and 1.
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("single_beat%0d", i), 64'(gnt_o[1]), 64'(sb_exp[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
